// File: rtl/user_word_sequencer.sv
// user_word_sequencer
// Latches a decoded user-word count on frame start, then moves exactly that
// many words from the source stream to the sink stream through one output
// register stage. The final word is tagged, and done pulses when the frame
// completes.
//
// Handshake semantics (both sides): a word moves on a rising edge where
// valid && ready are both high. A producer holds valid and its data stable
// until that edge, and valid never depends on ready. The source side here is
// the consumer (o_word_ready). The sink side here is the producer
// (o_user_valid / o_user_data / o_word_idx / o_user_last).
module user_word_sequencer #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [CNT_W-1:0]  i_user_word_count,
    input  logic [DATA_W-1:0] i_word_data,
    input  logic              i_word_valid,
    output logic              o_word_ready,
    output logic [DATA_W-1:0] o_user_data,
    output logic              o_user_valid,
    input  logic              i_user_ready,
    output logic              o_user_last,
    output logic [CNT_W-1:0]  o_word_idx,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err_overlap,
    output logic [1:0]        o_dbg_state,
    output logic [CNT_W-1:0]  o_dbg_snd_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Frame bookkeeping.
    logic [CNT_W-1:0] r_n;
    logic [CNT_W-1:0] r_acc_cnt;
    logic [CNT_W-1:0] r_snd_cnt;

    // Output register stage.
    logic [DATA_W-1:0] r_user_data;
    logic              r_user_valid;
    logic              r_user_last;
    logic [CNT_W-1:0]  r_word_idx;
    logic              r_err_overlap;

    logic w_start_acc;
    logic w_word_ready;
    logic w_src_xfer;
    logic w_snk_xfer;
    logic w_last_load;

    // The start pulse is acted on only in IDLE. The register may refill on the
    // same cycle it drains, which gives full throughput. The acc_cnt < n term
    // keeps the block from ever taking more than n words, so the counters
    // never wrap.
    assign w_start_acc  = (r_state == S_IDLE) && i_start;
    assign w_word_ready = (r_state == S_RUN) && (r_acc_cnt < r_n) &&
                          (!r_user_valid || i_user_ready);
    assign w_src_xfer   = i_word_valid && w_word_ready;
    assign w_snk_xfer   = r_user_valid && i_user_ready;
    assign w_last_load  = (r_acc_cnt == (r_n - CNT_W'(1)));

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic. An empty frame goes straight to DONE. A running frame
    // ends when the tagged last word leaves the sink side.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (i_user_word_count == '0) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (w_snk_xfer && r_user_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Latch the frame length on an accepted start. Count accepted and sent words.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_n       <= '0;
            r_acc_cnt <= '0;
            r_snd_cnt <= '0;
        end else if (w_start_acc) begin
            r_n       <= i_user_word_count;
            r_acc_cnt <= '0;
            r_snd_cnt <= '0;
        end else begin
            if (w_src_xfer) begin
                r_acc_cnt <= r_acc_cnt + CNT_W'(1);
            end
            if (w_snk_xfer) begin
                r_snd_cnt <= r_snd_cnt + CNT_W'(1);
            end
        end
    end

    // Output register: load on a source transfer and drain on a sink transfer.
    // Otherwise hold, which keeps data, index and last stable during a stall.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_user_data  <= '0;
            r_user_valid <= 1'b0;
            r_user_last  <= 1'b0;
            r_word_idx   <= '0;
        end else if (w_src_xfer) begin
            r_user_data  <= i_word_data;
            r_user_valid <= 1'b1;
            r_user_last  <= w_last_load;
            r_word_idx   <= r_acc_cnt;
        end else if (w_snk_xfer) begin
            r_user_valid <= 1'b0;
            r_user_last  <= 1'b0;
        end
    end

    // Flag a start pulse that arrives while a frame is still in progress.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_err_overlap <= 1'b0;
        end else begin
            r_err_overlap <= i_start && (r_state != S_IDLE);
        end
    end

    assign o_word_ready  = w_word_ready;
    assign o_user_data   = r_user_data;
    assign o_user_valid  = r_user_valid;
    assign o_user_last   = r_user_last;
    assign o_word_idx    = r_word_idx;
    assign o_busy        = (r_state != S_IDLE);
    assign o_done        = (r_state == S_DONE);
    assign o_err_overlap = r_err_overlap;
    assign o_dbg_state   = r_state;
    assign o_dbg_snd_cnt = r_snd_cnt;

endmodule

// File: tb/tb_user_word_sequencer.sv
// Bench for user_word_sequencer: a vector table for the basic frames plus
// multi-cycle sequences for stall, sparse source, overlap and async reset.
module tb_user_word_sequencer;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    // Clock and reset.
    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    always #5 i_clk = ~i_clk;

    logic              i_start;
    logic [CNT_W-1:0]  i_user_word_count;
    logic [DATA_W-1:0] i_word_data;
    logic              i_word_valid;
    logic              o_word_ready;
    logic [DATA_W-1:0] o_user_data;
    logic              o_user_valid;
    logic              i_user_ready;
    logic              o_user_last;
    logic [CNT_W-1:0]  o_word_idx;
    logic              o_busy;
    logic              o_done;
    logic              o_err_overlap;
    logic [1:0]        o_dbg_state;
    logic [CNT_W-1:0]  o_dbg_snd_cnt;

    user_word_sequencer #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .i_clk             (i_clk),
        .i_rst             (i_rst),
        .i_start           (i_start),
        .i_user_word_count (i_user_word_count),
        .i_word_data       (i_word_data),
        .i_word_valid      (i_word_valid),
        .o_word_ready      (o_word_ready),
        .o_user_data       (o_user_data),
        .o_user_valid      (o_user_valid),
        .i_user_ready      (i_user_ready),
        .o_user_last       (o_user_last),
        .o_word_idx        (o_word_idx),
        .o_busy            (o_busy),
        .o_done            (o_done),
        .o_err_overlap     (o_err_overlap),
        .o_dbg_state       (o_dbg_state),
        .o_dbg_snd_cnt     (o_dbg_snd_cnt)
    );

    int checks   = 0;
    int failures = 0;
    logic [DATA_W-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic              start;
        logic [CNT_W-1:0]  cnt;
        logic              wvalid;
        logic [DATA_W-1:0] wdata;
        logic              uready;
        logic              e_wready;
        logic              e_uvalid;
        logic [DATA_W-1:0] e_data;
        logic              e_last;
        logic [CNT_W-1:0]  e_idx;
        logic              e_busy;
        logic              e_done;
        logic              e_err;
    } vec_t;

    function automatic vec_t mk(input logic st, input logic [3:0] c, input logic wv,
                                input logic [31:0] wd, input logic ur, input logic ewr,
                                input logic euv, input logic [31:0] ed, input logic el,
                                input logic [3:0] ei, input logic eb, input logic edn,
                                input logic ee);
        vec_t v;
        v.start = st; v.cnt = c; v.wvalid = wv; v.wdata = wd; v.uready = ur;
        v.e_wready = ewr; v.e_uvalid = euv; v.e_data = ed; v.e_last = el;
        v.e_idx = ei; v.e_busy = eb; v.e_done = edn; v.e_err = ee;
        return v;
    endfunction

    // Multi-cycle frame driver with a sink-side scoreboard. stall_idx holds
    // the sink off for 3 cycles while that word is presented. tog makes
    // source valid alternate. ovl_at re-pulses start at that loop cycle.
    // abort_after asserts reset asynchronously after that word is sent.
    task automatic run_frame(input int n, input bit tog, input int stall_idx,
                             input int ovl_at, input int abort_after,
                             input logic [DATA_W-1:0] base);
        int src_cnt = 0;
        int snd_cnt = 0;
        int err_cnt = 0;
        int done_cnt = 0;
        int stall_left = 3;
        int cyc = 0;
        bit finished = 0;
        bit aborted = 0;
        bit have_prev = 0;
        logic [DATA_W-1:0] prev_data = '0;
        logic [CNT_W-1:0]  prev_idx = '0;
        logic [DATA_W-1:0] exp_w;
        exp_q.delete();
        for (int k = 0; k < n; k++) exp_q.push_back(base + DATA_W'(k));
        @(posedge i_clk); #1;
        i_start = 1'b1; i_user_word_count = CNT_W'(n);
        i_word_valid = 1'b0; i_user_ready = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0; i_user_word_count = 4'd7;
        while (!finished && cyc < 200) begin
            i_word_valid = tog ? (cyc % 2 == 0) : 1'b1;
            i_word_data  = base + DATA_W'(src_cnt);
            i_start      = (cyc == ovl_at);
            if (stall_idx >= 0 && o_user_valid && o_word_idx == CNT_W'(stall_idx) && stall_left > 0) begin
                i_user_ready = 1'b0;
                stall_left--;
            end else begin
                i_user_ready = 1'b1;
            end
            @(negedge i_clk);
            if (have_prev) begin
                check("stall_data_hold", o_user_data, prev_data);
                check("stall_idx_hold", o_word_idx, prev_idx);
            end
            have_prev = 0;
            if (o_user_valid && !i_user_ready) begin
                check("stall_ready_low", o_word_ready, 0);
                have_prev = 1; prev_data = o_user_data; prev_idx = o_word_idx;
            end
            if (o_err_overlap) err_cnt++;
            if (o_done) begin done_cnt++; finished = 1; end
            if (o_word_ready && i_word_valid) src_cnt++;
            if (o_user_valid && i_user_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL sink_extra_word actual=%0h required=none", o_user_data);
                end else begin
                    exp_w = exp_q.pop_front();
                    check("sink_data", o_user_data, exp_w);
                    check("sink_idx", o_word_idx, snd_cnt);
                    check("sink_last", o_user_last, (snd_cnt == n - 1));
                end
                if (snd_cnt == abort_after) aborted = 1;
                snd_cnt++;
            end
            @(posedge i_clk); #1;
            cyc++;
            if (aborted) begin
                #2;
                i_rst = 1'b1;
                #1;
                check("async_reset_clear",
                      {o_user_valid, o_user_last, o_busy, o_word_ready, o_done, o_err_overlap, o_word_idx, o_user_data},
                      '0);
                @(posedge i_clk); #1;
                @(posedge i_clk); #1;
                i_rst = 1'b0;
                finished = 1;
            end
        end
        i_start = 1'b0; i_word_valid = 1'b0; i_user_ready = 1'b1;
        if (!aborted) begin
            check("frame_done_count", done_cnt, 1);
            check("source_xfers", src_cnt, n);
            check("sink_xfers", snd_cnt, n);
            check("overlap_pulses", err_cnt, (ovl_at >= 0) ? 1 : 0);
            @(negedge i_clk);
            check("idle_after_frame", {o_busy, o_done, o_user_valid}, 3'b000);
        end
        exp_q.delete();
    endtask

    vec_t tbl[15];
    logic [9:0] act_v;
    logic [9:0] exp_v;

    initial begin
        i_start = 1'b0; i_user_word_count = '0; i_word_data = '0;
        i_word_valid = 1'b0; i_user_ready = 1'b1;

        // Basic frames: n=3 with both sides always ready, n=0, then n=1 with a
        // count change right after the latch.
        //            st  cnt  wv  wdata         ur  wr  uv  edata         l   idx bsy dn  err
        tbl[0]  = mk(1, 4'd3, 1, 32'hA000_0000, 1, 0, 0, 32'h0,         0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 4'd3, 1, 32'hA000_0000, 1, 1, 0, 32'h0,         0, 0, 1, 0, 0);
        tbl[2]  = mk(0, 4'd3, 1, 32'hA000_0001, 1, 1, 1, 32'hA000_0000, 0, 0, 1, 0, 0);
        tbl[3]  = mk(0, 4'd3, 1, 32'hA000_0002, 1, 1, 1, 32'hA000_0001, 0, 1, 1, 0, 0);
        tbl[4]  = mk(0, 4'd3, 1, 32'hA000_0003, 1, 0, 1, 32'hA000_0002, 1, 2, 1, 0, 0);
        tbl[5]  = mk(0, 4'd3, 0, 32'h0,         1, 0, 0, 32'h0,         0, 0, 1, 1, 0);
        tbl[6]  = mk(0, 4'd3, 0, 32'h0,         1, 0, 0, 32'h0,         0, 0, 0, 0, 0);
        tbl[7]  = mk(1, 4'd0, 1, 32'hB000_0000, 1, 0, 0, 32'h0,         0, 0, 0, 0, 0);
        tbl[8]  = mk(0, 4'd0, 1, 32'hB000_0000, 1, 0, 0, 32'h0,         0, 0, 1, 1, 0);
        tbl[9]  = mk(0, 4'd0, 1, 32'hB000_0000, 1, 0, 0, 32'h0,         0, 0, 0, 0, 0);
        tbl[10] = mk(1, 4'd1, 1, 32'hC000_0000, 1, 0, 0, 32'h0,         0, 0, 0, 0, 0);
        tbl[11] = mk(0, 4'd9, 1, 32'hC000_0000, 1, 1, 0, 32'h0,         0, 0, 1, 0, 0);
        tbl[12] = mk(0, 4'd9, 1, 32'hC000_0001, 1, 0, 1, 32'hC000_0000, 1, 0, 1, 0, 0);
        tbl[13] = mk(0, 4'd9, 1, 32'hC000_0001, 1, 0, 0, 32'h0,         0, 0, 1, 1, 0);
        tbl[14] = mk(0, 4'd9, 0, 32'h0,         1, 0, 0, 32'h0,         0, 0, 0, 0, 0);

        repeat (3) @(posedge i_clk);
        #1;
        check("reset_state",
              {o_user_valid, o_user_last, o_busy, o_word_ready, o_done, o_err_overlap, o_word_idx, o_user_data},
              '0);
        i_rst = 1'b0;

        for (int r = 0; r < 15; r++) begin
            @(posedge i_clk); #1;
            i_start = tbl[r].start; i_user_word_count = tbl[r].cnt;
            i_word_valid = tbl[r].wvalid; i_word_data = tbl[r].wdata;
            i_user_ready = tbl[r].uready;
            @(negedge i_clk);
            act_v = {o_word_ready, o_user_valid, o_user_last,
                     (o_user_valid ? o_word_idx : 4'd0), o_busy, o_done, o_err_overlap};
            exp_v = {tbl[r].e_wready, tbl[r].e_uvalid, tbl[r].e_last,
                     (tbl[r].e_uvalid ? tbl[r].e_idx : 4'd0), tbl[r].e_busy, tbl[r].e_done, tbl[r].e_err};
            check($sformatf("vec%0d_ctrl", r), act_v, exp_v);
            if (tbl[r].e_uvalid) check($sformatf("vec%0d_data", r), o_user_data, tbl[r].e_data);
        end
        @(posedge i_clk); #1;
        i_start = 1'b0; i_word_valid = 1'b0;

        run_frame(4, 1'b0, 1, -1, -1, 32'h4000_0000);
        run_frame(5, 1'b1, -1, -1, -1, 32'h5000_0000);
        run_frame(2, 1'b0, -1, 1, -1, 32'h2000_0000);
        run_frame(15, 1'b0, -1, -1, 6, 32'hF000_0000);
        run_frame(1, 1'b0, -1, -1, -1, 32'h1000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/user_word_sequencer.md
Name: user_word_sequencer

Overview:
- Sits directly downstream of the user-word-count decoder.
- On a frame-start pulse it latches the decoded 4-bit user word count and transfers exactly that many user words from a source stream to a sink stream, tagging the final word.
- It then pulses done and returns to idle.
- Provides one output register stage with full throughput, using valid/ready handshakes on both sides.

Parameters:
DATA_W, 32, width of a user word.
CNT_W, 4, width of the word count; must match the decoder output width.

Ports:
i_clk  input  1  clock, all state on rising edge
i_rst  input  1  asynchronous active-high reset
i_start  input  1  frame-start pulse; sampled only in IDLE
i_user_word_count  input  CNT_W  decoded word count, latched on accepted start
i_word_data  input  DATA_W  source word
i_word_valid  input  1  source word valid
o_word_ready  output  1  block accepts source word this cycle
o_user_data  output  DATA_W  registered word to sink
o_user_valid  output  1  o_user_data valid
i_user_ready  input  1  sink accepts word this cycle
o_user_last  output  1  qualifies final word of frame, valid only with o_user_valid
o_word_idx  output  CNT_W  index (0-based) of word currently on o_user_data
o_busy  output  1  high in RUN and DONE
o_done  output  1  one-cycle pulse, frame complete
o_err_overlap  output  1  one-cycle pulse, i_start seen while not IDLE

Behaviour:
- Reset (async assert, sync release) forces the following, and any in-flight word is discarded:
  - state=IDLE
  - all counters 0
  - o_user_valid=0, o_user_last=0, o_done=0, o_err_overlap=0, o_busy=0
  - o_user_data=0, o_word_idx=0
- States: IDLE, RUN, DONE.
- IDLE:
  - o_word_ready=0.
  - On i_start: latch n=i_user_word_count; clear acc_cnt and snd_cnt.
  - If n!=0, go to RUN.
  - If n==0, go to DONE. No data is transferred and o_done is asserted the next cycle.
- RUN:
  - Source handshake:
    - o_word_ready = (acc_cnt<n) && (!o_user_valid || i_user_ready).
    - A transfer is i_word_valid && o_word_ready; on transfer, acc_cnt increments.
  - Output register:
    - A source transfer at cycle k loads o_user_data and sets o_user_valid at k+1.
    - o_word_idx takes acc_cnt, the pre-increment value.
    - o_user_last = (acc_cnt==n-1) at load.
  - Sink handshake:
    - A transfer is o_user_valid && i_user_ready; on transfer, snd_cnt increments.
    - o_user_valid clears unless the register is refilled the same cycle.
    - o_user_data/o_word_idx/o_user_last must hold stable while o_user_valid && !i_user_ready.
  - Throughput: 1 word/cycle with both sides always ready. Latency source-to-sink is 1 cycle.
  - When the sink transfer of the word with o_user_last=1 occurs, go to DONE.
- DONE:
  - o_done=1 for exactly this one cycle; o_word_ready=0, o_user_valid=0.
  - Unconditionally return to IDLE.
  - A new i_start is accepted no earlier than the cycle after DONE.
- Overlap: i_start in RUN or DONE is ignored (the latched n is unchanged) and o_err_overlap=1 the next cycle.
- i_user_word_count changes after latch have no effect on the current frame.
- Counters are CNT_W bits wide and never wrap: acc_cnt saturates at n via ready gating. n=15 (max) must transfer exactly 15 words.
- o_busy = (state!=IDLE).

Test Plan:
- n=3, source and sink always ready:
  - i_start at T → o_word_ready from T+1.
  - Words D0,D1,D2 appear on o_user_valid at T+2..T+4 with idx 0,1,2, and o_user_last only on D2.
  - o_done at T+5, then IDLE.
- n=0 (su-mode decode):
  - i_start at T → o_done at T+1.
  - o_word_ready and o_user_valid never assert; o_busy high for one cycle only.
- n=4 with i_user_ready low for 3 cycles while word 1 is presented:
  - o_user_data/idx held stable.
  - o_word_ready=0 during the stall.
  - All 4 words delivered in order, with no duplicates or drops.
- n=5 with i_word_valid toggling 1,0,1,0: exactly 5 source transfers, o_user_last on idx 4, and a 6th pending source word is never accepted.
- n=2, i_start re-pulsed mid-frame with i_user_word_count=7: o_err_overlap pulses once and the frame still ends after 2 words.
- n=15 with i_rst asserted asynchronously after word 6:
  - Outputs clear immediately without waiting for a clock edge.
  - Post-reset: a new i_start with n=1 delivers exactly 1 word with o_user_last=1 and o_word_idx=0.
